bus_transfer_sequencer: RTL and testbench

//  Write side of the 32-bit datapath bus. Queues register-transfer requests (source code, destination code)
//  and turns each into a timed pair of one-hot strobes. src_out[] drives the bus-mux select enables.
//  dst_in[] drives the register load enables. Sits between the control unit and the bus/register file.

---
 rtl/bus_transfer_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// bus_transfer_sequencer
//
// Write side of the 32-bit datapath bus. Register-transfer requests
// (source code, destination code) are queued in a small FIFO and each one is
// played out as a timed pair of one-hot strobes. First the source drives the
// bus (DRIVE), then the destination loads it while the source is still
// driving (LOAD). At most one bus driver and at most one loader are active in
// any cycle.
//
// Ports
//   clock      in   1     system clock, rising edge
//   clear      in   1     synchronous active-low reset
//   req_valid  in   1     request present
//   req_src    in   5     source code (0..NSRC-1 legal)
//   req_dst    in   5     destination code (0..NDST-1 legal)
//   req_ready  out  1     request accepted when req_valid & req_ready
//   stall      in   1     holds the sequencer in DRIVE
//   src_out    out  NSRC  one-hot bus-drive enables (registered)
//   dst_in     out  NDST  one-hot register load enables (registered)
//   done       out  1     one-cycle pulse, coincident with dst_in
//   err        out  1     one-cycle pulse after an illegal request handshake
//   busy       out  1     transfer in flight or requests queued
// -----------------------------------------------------------------------------
module bus_transfer_sequencer #(
    parameter int DEPTH = 4,
    parameter int NSRC  = 24,
    parameter int NDST  = 24
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            req_valid,
    input  logic [4:0]      req_src,
    input  logic [4:0]      req_dst,
    output logic            req_ready,
    input  logic            stall,
    output logic [NSRC-1:0] src_out,
    output logic [NDST-1:0] dst_in,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Request FIFO. Each entry packs {src, dst}. With only a handful of
    // entries the head is read directly so the pop edge can also register
    // the new source strobe.
    logic [9:0]       fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             fifo_full, fifo_empty;

    logic [4:0] cur_src_reg, cur_dst_reg;
    logic [4:0] cur_src_next, cur_dst_next;
    logic [4:0] head_src, head_dst;

    logic handshake, legal, push, pop;

    logic [NSRC-1:0] src_onehot, src_next;
    logic [NDST-1:0] dst_onehot, dst_next;
    logic            done_next;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    assign req_ready = clear & ~fifo_full;
    assign handshake = req_valid & req_ready;
    assign legal     = ({27'd0, req_src} < 32'(NSRC)) && ({27'd0, req_dst} < 32'(NDST));
    // Illegal requests complete the handshake but never reach the queue.
    assign push      = handshake & legal;
    // The head is taken whenever the sequencer is about to start a new DRIVE.
    assign pop       = clear & ~fifo_empty & ((state_reg == IDLE) || (state_reg == LOAD));

    assign {head_src, head_dst} = fifo_mem[rd_ptr_reg];

    assign busy = (state_reg != IDLE) || !fifo_empty;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_src, req_dst};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Current transfer register.
    assign cur_src_next = pop ? head_src : cur_src_reg;
    assign cur_dst_next = pop ? head_dst : cur_dst_reg;

    always_ff @(posedge clock) begin
        if (!clear) begin
            cur_src_reg <= '0;
            cur_dst_reg <= '0;
        end else begin
            cur_src_reg <= cur_src_next;
            cur_dst_reg <= cur_dst_next;
        end
    end

    // FSM: state register.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!fifo_empty) state_next = DRIVE;
            DRIVE:   if (!stall)      state_next = LOAD;
            LOAD:    state_next = fifo_empty ? IDLE : DRIVE;
            default: state_next = IDLE;
        endcase
    end

    // One-hot decoders for the transfer that will be current next cycle.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src_dec
            assign src_onehot[gi] = ({27'd0, cur_src_next} == 32'(gi));
        end
        for (genvar gi = 0; gi < NDST; gi++) begin : g_dst_dec
            assign dst_onehot[gi] = ({27'd0, cur_dst_next} == 32'(gi));
        end
    endgenerate

    // FSM: output logic, evaluated for the upcoming state so the strobes
    // can be registered and stay glitch-free on the bus selects.
    always_comb begin
        src_next  = '0;
        dst_next  = '0;
        done_next = 1'b0;
        case (state_next)
            DRIVE: begin
                src_next = src_onehot;
            end
            LOAD: begin
                src_next  = src_onehot;
                dst_next  = dst_onehot;
                done_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            src_out <= '0;
            dst_in  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            src_out <= src_next;
            dst_in  <= dst_next;
            done    <= done_next;
            err     <= handshake & ~legal;
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_transfer_sequencer
//
// Directed and randomized stimulus for bus_transfer_sequencer. Expected
// outputs come from a transaction-level model: a queue of pending transfers
// plus the stage (none / bus driven / loading) of the transfer in flight.
// -----------------------------------------------------------------------------
module tb_bus_transfer_sequencer;

    localparam int DEPTH = 4;
    localparam int NSRC  = 24;
    localparam int NDST  = 24;

    logic            clock;
    logic            clear;
    logic            req_valid;
    logic [4:0]      req_src;
    logic [4:0]      req_dst;
    logic            req_ready;
    logic            stall;
    logic [NSRC-1:0] src_out;
    logic [NDST-1:0] dst_in;
    logic            done;
    logic            err;
    logic            busy;

    bus_transfer_sequencer #(
        .DEPTH(DEPTH),
        .NSRC (NSRC),
        .NDST (NDST)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .req_valid(req_valid),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .req_ready(req_ready),
        .stall    (stall),
        .src_out  (src_out),
        .dst_in   (dst_in),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [9:0]  q[$];       // pending {src, dst}
    int          stage;      // 0: nothing in flight, 1: source driving, 2: loading
    logic [4:0]  cur_s, cur_d;
    logic [31:0] e_src, e_dst;
    logic        e_done, e_err, e_busy, e_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge(input logic v, input logic [4:0] s, input logic [4:0] d,
                              input logic st, input logic cl);
        logic hs, lg;
        int   nstage;
        if (!cl) begin
            q.delete();
            stage  = 0;
            e_src  = '0;
            e_dst  = '0;
            e_done = 1'b0;
            e_err  = 1'b0;
        end else begin
            hs = v && (q.size() < DEPTH);
            lg = (int'(s) < NSRC) && (int'(d) < NDST);
            nstage = stage;
            if (stage == 0 || stage == 2) begin
                if (q.size() > 0) begin
                    {cur_s, cur_d} = q.pop_front();
                    nstage = 1;
                end else begin
                    nstage = 0;
                end
            end else if (!st) begin
                nstage = 2;
            end
            if (hs && lg) q.push_back({s, d});
            stage  = nstage;
            e_src  = (stage != 0) ? (32'd1 << cur_s) : 32'd0;
            e_dst  = (stage == 2) ? (32'd1 << cur_d) : 32'd0;
            e_done = (stage == 2);
            e_err  = hs && !lg;
        end
        e_busy = (stage != 0) || (q.size() != 0);
    endtask

    // One clock cycle: drive at the falling edge, check ready, let the rising
    // edge happen, then check the registered outputs 1 time unit later.
    task automatic step(input logic v, input logic [4:0] s, input logic [4:0] d,
                        input logic st, input logic cl);
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        stall     = st;
        clear     = cl;
        #1;
        e_ready = cl && (q.size() < DEPTH);
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        model_edge(v, s, d, st, cl);
        @(posedge clock);
        #1;
        chk("src_out", 32'(src_out), e_src);
        chk("dst_in", 32'(dst_in), e_dst);
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("src_onehot0", 32'($onehot0(src_out)), 32'd1);
        chk("dst_onehot0", 32'($onehot0(dst_in)), 32'd1);
        chk("done_vs_dst", 32'(done), 32'(|dst_in));
        $display("step v=%0b src=%0d dst=%0d stall=%0b clear=%0b -> src_out=%06h dst_in=%06h done=%0b err=%0b busy=%0b",
                 v, s, d, st, cl, src_out, dst_in, done, err, busy);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, st, 1'b1);
    endtask

    initial begin
        stage     = 0;
        cur_s     = '0;
        cur_d     = '0;
        clear     = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        stall     = 1'b0;
        @(negedge clock);

        // 1. Reset held for two cycles, then released.
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        clear = 1'b1;
        #1;
        chk("release_ready", 32'(req_ready), 32'd1);

        // 2. Single transfer R3 -> Y with the literal waveform.
        step(1'b1, 5'd3, 5'd21, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("single_n1_src", 32'(src_out), 32'h000008);
        chk("single_n1_dst", 32'(dst_in), 32'h0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("single_n2_src", 32'(src_out), 32'h000008);
        chk("single_n2_dst", 32'(dst_in), 32'h200000);
        chk("single_n2_done", 32'(done), 32'd1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("single_n3_src", 32'(src_out), 32'h0);
        chk("single_n3_busy", 32'(busy), 32'd0);

        // 3. Fill the queue while the first transfer is stalled.
        for (int i = 0; i < 6; i++)
            step(1'b1, 5'($urandom_range(0, NSRC - 1)), 5'($urandom_range(0, NDST - 1)), 1'b1, 1'b1);
        chk("fill_ready_low", 32'(req_ready), 32'd0);
        idle(2, 1'b1);
        idle(12, 1'b0);

        // 4. PC -> MAR with stall held for three cycles in DRIVE.
        step(1'b1, 5'd20, 5'd19, 1'b0, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("stall_src_held", 32'(src_out), 32'h100000);
        chk("stall_no_load", 32'(dst_in), 32'h0);
        idle(3, 1'b0);

        // 5. Illegal source code.
        step(1'b1, 5'd24, 5'd2, 1'b0, 1'b1);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_busy", 32'(busy), 32'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("illegal_err_clear", 32'(err), 32'd0);
        chk("illegal_no_src", 32'(src_out), 32'h0);

        // 6. Reset during DRIVE with two requests queued.
        step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1);
        step(1'b1, 5'd4, 5'd5, 1'b1, 1'b1);
        step(1'b1, 5'd6, 5'd7, 1'b1, 1'b1);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dst", 32'(dst_in), 32'h0);

        // 7. Randomized traffic including illegal codes, stalls and resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 25)),
                 5'($urandom_range(0, 25)),
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 49) != 0));
        end
        idle(12, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
